// File: rtl/decoder_scan_seq.sv
// Scan sequencer for a 3-to-8 decoder: blanked time slots over 0..LAST,
// single-step launch and a force override that holds one address.
module decoder_scan_seq #(
  parameter int PRESCALE = 4,
  parameter int BLANK    = 1,
  parameter int LAST     = 7
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       run,
  input  logic       step,
  input  logic       force_vld,
  input  logic [2:0] force_addr,
  output logic       en,
  output logic       a,
  output logic       b,
  output logic       c,
  output logic       slot_done,
  output logic       wrap
);

  localparam int MX  = (PRESCALE > BLANK) ? PRESCALE : BLANK;
  localparam int CL  = $clog2(MX + 1);
  localparam int CW  = (CL < 1) ? 1 : CL;

  localparam logic [CW-1:0] PS_LD =
    CW'(PRESCALE - 1);
  localparam logic [CW-1:0] BL_LD =
    CW'((BLANK == 0) ? 0 : BLANK - 1);
  localparam logic [2:0] LAST_A = 3'(LAST);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BLANK,
    S_DRIVE,
    S_FORCE
  } state_t;

  // Slot entry skips the gap entirely when BLANK is zero
  localparam state_t S_GO =
    (BLANK == 0) ? S_DRIVE : S_BLANK;

  state_t        state;
  state_t        state_nxt;
  logic [2:0]    addr;
  logic [2:0]    faddr;
  logic [CW-1:0] cnt;
  logic          one_slot;

  logic cnt_z;
  logic slot_end;
  logic take_step;
  logic at_last;

  assign cnt_z     = (cnt == '0);
  assign slot_end  = (state == S_DRIVE) && cnt_z;
  assign at_last   = (addr == LAST_A);
  assign take_step = (state == S_IDLE)
                   && !force_vld
                   && !run
                   && step;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr     <= '0;
      faddr    <= '0;
      cnt      <= '0;
      one_slot <= 1'b0;
    end else begin
      if (slot_end) begin
        addr <= at_last ? 3'd0 : addr + 3'd1;
      end

      if (state_nxt == S_FORCE
          && state != S_FORCE) begin
        faddr <= force_addr;
      end

      unique case (state_nxt)
        S_BLANK: begin
          if (state != S_BLANK) begin
            cnt <= BL_LD;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        S_DRIVE: begin
          if (state != S_DRIVE || cnt_z) begin
            cnt <= PS_LD;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        default: cnt <= '0;
      endcase

      // A step launches one slot; leaving the scan cancels it
      if (take_step) begin
        one_slot <= 1'b1;
      end else if (state_nxt == S_IDLE
                   || state_nxt == S_FORCE) begin
        one_slot <= 1'b0;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE: begin
        if (force_vld) begin
          state_nxt = S_FORCE;
        end else if (run || step) begin
          state_nxt = S_GO;
        end
      end
      S_BLANK: begin
        if (force_vld) begin
          state_nxt = S_FORCE;
        end else if (cnt_z) begin
          state_nxt = S_DRIVE;
        end
      end
      S_DRIVE: begin
        if (cnt_z) begin
          if (force_vld) begin
            state_nxt = S_FORCE;
          end else if (run && !one_slot) begin
            state_nxt = S_GO;
          end else begin
            state_nxt = S_IDLE;
          end
        end
      end
      S_FORCE: begin
        if (!force_vld) begin
          state_nxt = run ? S_GO : S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    en        = 1'b0;
    {a, b, c} = addr;
    slot_done = 1'b0;
    wrap      = 1'b0;
    unique case (1'b1)
      (state == S_DRIVE): begin
        en        = 1'b1;
        slot_done = cnt_z;
        wrap      = cnt_z && at_last;
      end
      (state == S_FORCE): begin
        en        = 1'b1;
        {a, b, c} = faddr;
      end
      default: begin
        en = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_decoder_scan_seq.sv
// Scoreboard bench for decoder_scan_seq: default build plus a
// LAST=2 / BLANK=0 / PRESCALE=1 variant.
module tb_decoder_scan_seq;

  localparam int P  = 4;
  localparam int BL = 1;
  localparam int LA = 7;

  logic       clk;
  logic       rst_n;
  logic       run;
  logic       step;
  logic       fv;
  logic [2:0] fa;
  logic       run2;

  logic en1, a1, b1, c1, sd1, wr1;
  logic en2, a2, b2, c2, sd2, wr2;
  logic [5:0] o1;
  logic [5:0] o2;

  int n_cmp;
  int n_err;
  logic [5:0] q[$];

  assign o1 = {en1, a1, b1, c1, sd1, wr1};
  assign o2 = {en2, a2, b2, c2, sd2, wr2};

  decoder_scan_seq #(
    .PRESCALE(P), .BLANK(BL), .LAST(LA)
  ) u_dut (
    .clk(clk), .rst_n(rst_n),
    .run(run), .step(step),
    .force_vld(fv), .force_addr(fa),
    .en(en1), .a(a1), .b(b1), .c(c1),
    .slot_done(sd1), .wrap(wr1)
  );

  decoder_scan_seq #(
    .PRESCALE(1), .BLANK(0), .LAST(2)
  ) u_var (
    .clk(clk), .rst_n(rst_n),
    .run(run2), .step(1'b0),
    .force_vld(1'b0), .force_addr(3'd0),
    .en(en2), .a(a2), .b(b2), .c(c2),
    .slot_done(sd2), .wrap(wr2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(
    input string      tag,
    input logic [5:0] got,
    input logic [5:0] exp
  );
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %b want %b (en abc sd wr)",
               tag, got, exp);
    end
  endtask

  function automatic logic [5:0] mk(
    input bit e, input int ad,
    input bit sd, input bit w
  );
    return {e, 3'(ad), sd, w};
  endfunction

  task automatic push(input logic [5:0] v, input int n = 1);
    for (int i = 0; i < n; i++) q.push_back(v);
  endtask

  task automatic push_drive(input int ad);
    for (int i = 0; i < P; i++)
      push(mk(1, ad, i == P - 1, (i == P - 1) && (ad == LA)));
  endtask

  task automatic push_slot(input int ad);
    push(mk(0, ad, 0, 0), BL);
    push_drive(ad);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic run_cycles(
    input string tag, input int n, input bit sel = 0
  );
    logic [5:0] e;
    for (int i = 0; i < n; i++) begin
      tick();
      if (q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL %s: scoreboard empty", tag);
      end else begin
        e = q.pop_front();
        chk(tag, sel ? o2 : o1, e);
      end
    end
  endtask

  task automatic do_step(input int ad);
    step = 1'b1;
    push(mk(0, ad, 0, 0));
    run_cycles("step_blank", 1);
    step = 1'b0;
    push_drive(ad);
    push(mk(0, (ad + 1) % 8, 0, 0), 2);
    run_cycles("step_slot", P + 2);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b1;
    run   = 1'b0;
    step  = 1'b0;
    fv    = 1'b0;
    fa    = 3'd0;
    run2  = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    chk("rst_main", o1, 6'd0);
    chk("rst_var", o2, 6'd0);
    tick();
    tick();
    rst_n = 1'b1;
    push(mk(0, 0, 0, 0), 2);
    run_cycles("idle", 2);

    run = 1'b1;
    for (int ad = 0; ad < 8; ad++) push_slot(ad);
    push_slot(0);
    push_slot(1);
    run_cycles("scan", 10 * (BL + P));

    push(mk(0, 2, 0, 0));
    push(mk(1, 2, 0, 0), 2);
    run_cycles("pre_force", 3);
    fv = 1'b1;
    fa = 3'd5;
    push(mk(1, 2, 0, 0));
    push(mk(1, 2, 1, 0));
    push(mk(1, 5, 0, 0), 3);
    run_cycles("force_in", 5);
    fa = 3'd0;
    push(mk(1, 5, 0, 0), 3);
    run_cycles("force_hold", 3);
    fv = 1'b0;
    push_slot(3);
    run_cycles("force_out", BL + P);

    push(mk(0, 4, 0, 0));
    push(mk(1, 4, 0, 0));
    run_cycles("pre_drop", 2);
    run = 1'b0;
    push(mk(1, 4, 0, 0), 2);
    push(mk(1, 4, 1, 0));
    push(mk(0, 5, 0, 0), 3);
    run_cycles("run_drop", 6);
    run = 1'b1;
    push_slot(5);
    push(mk(0, 6, 0, 0));
    push(mk(1, 6, 0, 0));
    run_cycles("resume", 7);
    run = 1'b0;
    push(mk(1, 6, 0, 0), 2);
    push(mk(1, 6, 1, 0));
    push(mk(0, 7, 0, 0), 2);
    run_cycles("stop", 5);

    step = 1'b1;
    push(mk(0, 7, 0, 0));
    run_cycles("step7_blank", 1);
    step = 1'b0;
    push(mk(1, 7, 0, 0), 2);
    run_cycles("step7_drive", 2);
    step = 1'b1;
    push(mk(1, 7, 0, 0));
    run_cycles("step_drop", 1);
    step = 1'b0;
    push(mk(1, 7, 1, 1));
    push(mk(0, 0, 0, 0), 3);
    run_cycles("step7_end", 4);

    do_step(0);
    do_step(1);
    do_step(2);

    step = 1'b1;
    push(mk(0, 3, 0, 0));
    run_cycles("pre_rst", 1);
    step = 1'b0;
    push(mk(1, 3, 0, 0), 2);
    run_cycles("pre_rst", 2);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst", o1, 6'd0);
    tick();
    tick();
    rst_n = 1'b1;
    push(mk(0, 0, 0, 0), 2);
    run_cycles("post_rst", 2);

    run2 = 1'b1;
    for (int i = 0; i < 7; i++)
      push(mk(1, i % 3, 1, (i % 3) == 2));
    run_cycles("variant", 7, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
